holiday_lights_monitor: RTL and testbench

Receive-side checker for the 16-bit rotating holiday-light bus. It samples the LED vector and decodes the loaded pattern width (the inverse of the 3-bit switch code) and the current rotation position. It also checks that each rotation is a single left-rotate arriving on the expected period. It sits beside the light generator on the board, or in the bench as a scoreboard, and reports lock, rotation pulses and error codes.

---
 rtl/holiday_lights_monitor_pkg.sv | 19 +
 rtl/holiday_lights_monitor_if.sv | 28 ++
 rtl/holiday_lights_monitor_classify.sv | 33 +++
 rtl/holiday_lights_monitor.sv | 173 +++++++++++++++++
 tb/tb_holiday_lights_monitor.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/holiday_lights_monitor_pkg.sv
// Shared state encoding, error codes and bit helpers
// for the rotating holiday-light bus monitor.
package holiday_lights_monitor_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOCK  = 2'd1;
    localparam logic [1:0] S_TRACK = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_SHAPE  = 2'b01;
    localparam logic [1:0] ERR_TIMING = 2'b10;
    localparam logic [1:0] ERR_STALL  = 2'b11;

    function automatic logic [15:0] rotl1(input logic [15:0] x);
        return {x[14:0], x[15]};
    endfunction

endpackage

// File: rtl/holiday_lights_monitor_if.sv
// Light bus observed by the monitor plus its status outputs.
// The bench drives through master; the monitor uses slave.
interface holiday_lights_monitor_if;

    logic [15:0] led_in;
    logic        err_clr;
    logic        locked;
    logic [2:0]  width;
    logic [3:0]  pos;
    logic        rot_pulse;
    logic        reload_pulse;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] rot_count;

    modport master (
        output led_in, err_clr,
        input  locked, width, pos, rot_pulse, reload_pulse,
        input  err, err_code, rot_count
    );

    modport slave (
        input  led_in, err_clr,
        output locked, width, pos, rot_pulse, reload_pulse,
        output err, err_code, rot_count
    );

endinterface

// File: rtl/holiday_lights_monitor_classify.sv
// Combinational classifier for a 16-bit circular run of 1..8 lit bits;
// reports run length minus one and the index of its lowest bit.
module light_pattern_classify
    import holiday_lights_monitor_pkg::*;
(
    input  logic [15:0] led_i,
    output logic        valid_o,
    output logic [2:0]  width_o,
    output logic [3:0]  pos_o
);

    logic [15:0] rise;
    logic [4:0]  ones;
    logic [4:0]  edges;

    // A rising boundary is a lit bit whose circular lower neighbour is dark.
    assign rise = led_i & ~rotl1(led_i);

    always_comb begin
        ones  = '0;
        edges = '0;
        pos_o = '0;
        for (int i = 0; i < 16; i++) begin
            ones  = ones + 5'(led_i[i]);
            edges = edges + 5'(rise[i]);
            if (rise[i]) pos_o = 4'(i);
        end
    end

    assign width_o = ones[2:0] - 3'd1;
    assign valid_o = (ones != 5'd0) && (ones <= 5'd8) && (edges == 5'd1);

endmodule

// File: rtl/holiday_lights_monitor.sv
// Receive-side checker: locks onto a rotating light pattern, times each
// single-step left rotation and reports sticky shape/timing/stall errors.
module holiday_lights_monitor
    import holiday_lights_monitor_pkg::*;
#(
    parameter int unsigned PERIOD = 100_000_001,
    parameter int unsigned TOL    = 4,
    parameter int unsigned CW     = 32
) (
    input  logic clk,
    input  logic rst_n,
    holiday_lights_monitor_if.slave bus
);

    localparam logic [CW-1:0] WIN_LO = CW'(PERIOD - TOL);
    localparam logic [CW-1:0] WIN_HI = CW'(PERIOD + TOL);
    localparam logic [CW-1:0] LIMIT  = CW'(PERIOD + TOL + 1);

    logic [15:0]   led_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    width_q, width_d;
    logic [3:0]    pos_q, pos_d;
    logic          rot_q, rot_d;
    logic          reload_q, reload_d;
    logic [1:0]    code_q, code_d;
    logic [15:0]   rcnt_q, rcnt_d;

    logic          cls_valid;
    logic [2:0]    cls_width;
    logic [3:0]    cls_pos;
    logic          chg;
    logic          is_rot;
    logic          is_zero;
    logic [CW-1:0] cnt1;
    logic          in_win;
    logic [15:0]   rcnt_inc;

    light_pattern_classify u_cls (
        .led_i   (bus.led_in),
        .valid_o (cls_valid),
        .width_o (cls_width),
        .pos_o   (cls_pos)
    );

    assign chg      = bus.led_in != led_q;
    assign is_rot   = bus.led_in == rotl1(led_q);
    assign is_zero  = bus.led_in == 16'h0000;
    assign cnt1     = cnt_q + CW'(1);
    assign in_win   = (cnt1 >= WIN_LO) && (cnt1 <= WIN_HI);
    assign rcnt_inc = (rcnt_q == 16'hFFFF) ? rcnt_q : rcnt_q + 16'd1;

    always_comb begin
        state_d  = state_q;
        width_d  = width_q;
        pos_d    = pos_q;
        rot_d    = 1'b0;
        reload_d = 1'b0;
        code_d   = code_q;
        rcnt_d   = rcnt_q;
        cnt_d    = cnt_q;

        if (chg) begin
            cnt_d = '0;
        end else if ((state_q == S_LOCK || state_q == S_TRACK)
                     && cnt_q != LIMIT) begin
            cnt_d = cnt1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (chg && cls_valid) begin
                    state_d = S_LOCK;
                    width_d = cls_width;
                    pos_d   = cls_pos;
                end else if (chg && !is_zero) begin
                    state_d = S_ERR;
                    code_d  = ERR_SHAPE;
                end
            end
            // First interval after a load is untimed.
            S_LOCK: begin
                if (chg) begin
                    if (is_rot) begin
                        state_d = S_TRACK;
                        rot_d   = 1'b1;
                        rcnt_d  = 16'd1;
                        pos_d   = pos_q + 4'd1;
                    end else if (cls_valid) begin
                        reload_d = 1'b1;
                        width_d  = cls_width;
                        pos_d    = cls_pos;
                    end else if (is_zero) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ERR;
                        code_d  = ERR_SHAPE;
                    end
                end
            end
            S_TRACK: begin
                if (chg) begin
                    if (is_rot && in_win) begin
                        rot_d  = 1'b1;
                        rcnt_d = rcnt_inc;
                        pos_d  = pos_q + 4'd1;
                    end else if (is_rot) begin
                        state_d = S_ERR;
                        code_d  = ERR_TIMING;
                    end else if (cls_valid) begin
                        state_d  = S_LOCK;
                        reload_d = 1'b1;
                        rcnt_d   = '0;
                        width_d  = cls_width;
                        pos_d    = cls_pos;
                    end else if (is_zero) begin
                        state_d = S_IDLE;
                        rcnt_d  = '0;
                    end else begin
                        state_d = S_ERR;
                        code_d  = ERR_SHAPE;
                    end
                end else if (cnt1 >= LIMIT) begin
                    state_d = S_ERR;
                    code_d  = ERR_STALL;
                end
            end
            // Clear wins over any change arriving in the same cycle.
            S_ERR: begin
                if (bus.err_clr) begin
                    state_d = S_IDLE;
                    code_d  = ERR_NONE;
                    rcnt_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q    <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            width_q  <= '0;
            pos_q    <= '0;
            rot_q    <= 1'b0;
            reload_q <= 1'b0;
            code_q   <= ERR_NONE;
            rcnt_q   <= '0;
        end else begin
            led_q    <= bus.led_in;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            width_q  <= width_d;
            pos_q    <= pos_d;
            rot_q    <= rot_d;
            reload_q <= reload_d;
            code_q   <= code_d;
            rcnt_q   <= rcnt_d;
        end
    end

    assign bus.locked       = state_q == S_TRACK;
    assign bus.err          = state_q == S_ERR;
    assign bus.width        = width_q;
    assign bus.pos          = pos_q;
    assign bus.rot_pulse    = rot_q;
    assign bus.reload_pulse = reload_q;
    assign bus.err_code     = code_q;
    assign bus.rot_count    = rcnt_q;

endmodule

// File: tb/tb_holiday_lights_monitor.sv
// Directed and random bench for holiday_lights_monitor,
// checked cycle by cycle against a rule-level reference model.
module tb_holiday_lights_monitor;

    localparam int P = 10;
    localparam int T = 1;

    localparam int M_IDLE  = 0;
    localparam int M_LOCK  = 1;
    localparam int M_TRACK = 2;
    localparam int M_ERR   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    holiday_lights_monitor_if bus();

    holiday_lights_monitor #(
        .PERIOD (P),
        .TOL    (T),
        .CW     (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          m_mode;
    logic [15:0] m_prev;
    int          m_gap;
    int          m_width;
    int          m_pos;
    logic        m_rot;
    logic        m_rel;
    logic [1:0]  m_code;
    int          m_count;

    function automatic logic [15:0] rotl_n(input logic [15:0] x, input int n);
        logic [31:0] d;
        d = {x, x} << n;
        return d[31:16];
    endfunction

    // Valid iff x is some rotation of a contiguous block of 1..8 ones.
    task automatic ref_classify(input logic [15:0] x, output bit ok,
                                output int k, output int p);
        logic [15:0] base;
        ok = 0;
        k  = 0;
        p  = 0;
        for (int kk = 1; kk <= 8; kk++) begin
            base = 16'((32'd1 << kk) - 32'd1);
            for (int r = 0; r < 16; r++) begin
                if (x == rotl_n(base, r)) begin
                    ok = 1;
                    k  = kk;
                    p  = r;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_prev  = '0;
        m_gap   = 0;
        m_width = 0;
        m_pos   = 0;
        m_rot   = 0;
        m_rel   = 0;
        m_code  = 2'b00;
        m_count = 0;
    endtask

    task automatic model_step(input logic [15:0] led, input logic clr);
        bit ok;
        int k;
        int p;
        bit chg;
        bit isrot;
        int interval;
        ref_classify(led, ok, k, p);
        chg      = led != m_prev;
        isrot    = led == rotl_n(m_prev, 1);
        interval = m_gap + 1;
        m_rot    = 0;
        m_rel    = 0;
        case (m_mode)
            M_IDLE: begin
                if (chg && ok) begin
                    m_mode = M_LOCK; m_width = k - 1; m_pos = p;
                end else if (chg && led != 0) begin
                    m_mode = M_ERR; m_code = 2'b01;
                end
            end
            M_LOCK: begin
                if (chg) begin
                    if (isrot) begin
                        m_mode = M_TRACK; m_rot = 1; m_count = 1; m_pos = p;
                    end else if (ok) begin
                        m_rel = 1; m_width = k - 1; m_pos = p;
                    end else if (led == 0) begin
                        m_mode = M_IDLE;
                    end else begin
                        m_mode = M_ERR; m_code = 2'b01;
                    end
                end
            end
            M_TRACK: begin
                if (chg) begin
                    if (isrot && interval >= P - T && interval <= P + T) begin
                        m_rot = 1; m_pos = p;
                        m_count = (m_count < 65535) ? m_count + 1 : 65535;
                    end else if (isrot) begin
                        m_mode = M_ERR; m_code = 2'b10;
                    end else if (ok) begin
                        m_mode = M_LOCK; m_rel = 1; m_count = 0;
                        m_width = k - 1; m_pos = p;
                    end else if (led == 0) begin
                        m_mode = M_IDLE; m_count = 0;
                    end else begin
                        m_mode = M_ERR; m_code = 2'b01;
                    end
                end else if (interval == P + T + 1) begin
                    m_mode = M_ERR; m_code = 2'b11;
                end
            end
            default: begin
                if (clr) begin
                    m_mode = M_IDLE; m_code = 2'b00; m_count = 0;
                end
            end
        endcase
        m_gap  = chg ? 0 : ((m_gap < 100000) ? m_gap + 1 : m_gap);
        m_prev = led;
    endtask

    function automatic logic [28:0] observed();
        return {bus.locked, bus.width, bus.pos, bus.rot_pulse,
                bus.reload_pulse, bus.err, bus.err_code, bus.rot_count};
    endfunction

    function automatic logic [28:0] expected();
        return {m_mode == M_TRACK, 3'(m_width), 4'(m_pos), m_rot, m_rel,
                m_mode == M_ERR, m_code, 16'(m_count)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Width/pos are only meaningful while loaded (LOCK or TRACK).
    task automatic chk_model(input string tag);
        logic [28:0] mask;
        mask = (m_mode == M_LOCK || m_mode == M_TRACK) ? '1 : ~29'h0FE0_0000;
        chk(tag, 32'(observed() & mask), 32'(expected() & mask));
    endtask

    task automatic tick(input logic [15:0] led, input logic clr);
        @(negedge clk);
        bus.led_in  = led;
        bus.err_clr = clr;
        @(posedge clk);
        model_step(led, clr);
        #1;
        chk_model("model");
    endtask

    task automatic hold(input logic [15:0] led, input int n);
        for (int i = 0; i < n; i++) tick(led, 1'b0);
    endtask

    function automatic logic [15:0] rand_valid();
        int k;
        logic [15:0] b;
        k = int'($urandom_range(1, 8));
        b = 16'((32'd1 << k) - 32'd1);
        return rotl_n(b, int'($urandom_range(0, 15)));
    endfunction

    task automatic rand_invalid(output logic [15:0] x);
        bit ok;
        int k;
        int p;
        do begin
            x = 16'($urandom);
            ref_classify(x, ok, k, p);
        end while (ok || x == 16'h0000);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] cur;
        logic [15:0] nxt;
        int          npulse;
        int          gap;
        int          sel;
        logic        clr;

        bus.led_in  = '0;
        bus.err_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(observed()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        hold(16'h0000, 3);

        // Normal rotation run
        cur = 16'h0007;
        tick(cur, 1'b0);
        chk("load_width", 32'(bus.width), 32'd2);
        npulse = 0;
        for (int s = 1; s <= 20; s++) begin
            hold(cur, P - 1);
            cur = rotl_n(cur, 1);
            tick(cur, 1'b0);
            if (bus.rot_pulse) npulse++;
            if (s == 1) chk("locked_first_rot", 32'(bus.locked), 32'd1);
            if (s == 15) begin
                chk("led_8003", 32'(cur), 32'h8003);
                chk("pos_15", 32'(bus.pos), 32'd15);
            end
            if (s == 16) chk("pos_wrap", 32'(bus.pos), 32'd0);
        end
        chk("rot_pulses", 32'(npulse), 32'd20);
        chk("rot_count_20", 32'(bus.rot_count), 32'd20);
        chk("no_err_normal", 32'(bus.err), 32'd0);

        // Reload from TRACK
        tick(16'h0000, 1'b0);
        tick(16'h001C, 1'b0);
        hold(16'h001C, P - 1);
        tick(16'h0038, 1'b0);
        chk("track_38", 32'(bus.locked), 32'd1);
        hold(16'h0038, 4);
        tick(16'h00FF, 1'b0);
        chk("reload_pulse", 32'(bus.reload_pulse), 32'd1);
        chk("reload_state", 32'({bus.locked, bus.err}), 32'd0);
        chk("reload_wp", 32'({bus.width, bus.pos}), 32'h70);
        chk("reload_cnt", 32'(bus.rot_count), 32'd0);

        // Width-8 rotate, then early rotation
        hold(16'h00FF, P - 1);
        tick(16'h01FE, 1'b0);
        chk("w8_rot", 32'(bus.locked), 32'd1);
        hold(16'h01FE, 6);
        tick(16'h03FC, 1'b0);
        chk("timing_err", 32'({bus.err, bus.err_code, bus.locked}), 32'b1100);
        tick(16'h03FC, 1'b1);
        chk("timing_clr", 32'({bus.err, bus.err_code}), 32'd0);

        // Stall
        tick(16'h0003, 1'b0);
        hold(16'h0003, P - 1);
        tick(16'h0006, 1'b0);
        hold(16'h0006, P + T);
        chk("stall_not_yet", 32'(bus.err), 32'd0);
        tick(16'h0006, 1'b0);
        chk("stall_err", 32'({bus.err, bus.err_code}), 32'b111);
        tick(16'h0006, 1'b1);

        // Shape errors and clear-vs-change priority
        tick(16'h0505, 1'b0);
        chk("shape_0505", 32'(bus.err_code), 32'd1);
        tick(16'hFFFF, 1'b1);
        chk("clr_wins", 32'({bus.err, bus.err_code}), 32'd0);
        tick(16'h0000, 1'b0);
        tick(16'hFFFF, 1'b0);
        chk("shape_ffff", 32'({bus.err, bus.err_code}), 32'b101);
        tick(16'h0000, 1'b1);
        tick(16'h8001, 1'b0);
        chk("wrap_wp", 32'({bus.err, bus.width, bus.pos}), 32'h1F);

        // Async reset mid-TRACK
        hold(16'h8001, P - 1);
        tick(16'h0003, 1'b0);
        chk("pre_reset_track", 32'(bus.locked), 32'd1);
        #2;
        rst_n = 1'b0;
        bus.led_in = '0;
        #1;
        chk("async_reset", 32'(observed()), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        hold(16'h0000, 4);

        // Random traffic
        cur = '0;
        for (int e = 0; e < 300; e++) begin
            gap = int'($urandom_range(6, 13));
            for (int h = 1; h < gap; h++)
                tick(cur, $urandom_range(0, 19) == 0);
            sel = int'($urandom_range(0, 99));
            clr = (m_mode == M_ERR) && ($urandom_range(0, 1) == 1);
            if (sel < 70)
                nxt = (m_mode == M_IDLE) ? rand_valid() : rotl_n(cur, 1);
            else if (sel < 82)
                nxt = rand_valid();
            else if (sel < 88)
                nxt = 16'h0000;
            else if (sel < 95)
                rand_invalid(nxt);
            else
                nxt = cur;
            cur = nxt;
            tick(cur, clr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
